mem_word_master: RTL and testbench
==================================

Name: mem_word_master

Overview:
- Initiator side of the 8-bit byte-wide memory port (en/memwrite/adr/writedata/memdata, memory acts on negedge clk).
- Accepts 32-bit word read/write requests from the processor over a valid/ready handshake.
- Performs WORD_BYTES consecutive byte accesses, little-endian, and returns one completion pulse with the assembled read word.
- Sits between the MIPS core's load/store path and the byte memory.

Parameters:
ADDR_BITS, 8, width of byte address; address arithmetic is modulo 2^ADDR_BITS
WORD_BYTES, 4, bytes per request; data words are 8*WORD_BYTES bits

Ports:
clk  input  1  system clock; all state updates on posedge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = word write, 0 = word read
req_addr  input  ADDR_BITS  base byte address
req_wdata  input  8*WORD_BYTES  write word
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  8*WORD_BYTES  assembled read word
mem_en  output  1  to memory en
mem_memwrite  output  1  to memory memwrite
mem_adr  output  ADDR_BITS  to memory adr
mem_writedata  output  8  to memory writedata
mem_memdata  input  8  from memory memdata; updated on negedge

Behaviour:
- Interface decision: one clock (clk), reset asynchronous active-low (reset_n).
- Reset asserted, immediately and regardless of clk:
  - state=IDLE, byte counter=0.
  - req_ready=1, resp_valid=0, resp_rdata=0.
  - mem_en=0, mem_memwrite=0, mem_adr=0, mem_writedata=0.
- All outputs derive from registers only; there is no combinational path from any req_* input or mem_memdata to any output.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - req_ready=1 and mem_en=0.
  - On posedge with req_valid=1: latch req_write, req_addr and req_wdata; counter=0; go to XFER.
  - With req_valid=0: remain in IDLE.
- XFER (counter c = 0..WORD_BYTES-1, one cycle per byte):
  - req_ready=0 and mem_en=1.
  - mem_adr = (base + c) mod 2^ADDR_BITS.
  - mem_memwrite = latched write flag.
  - mem_writedata = wdata[8c+7:8c].
  - The memory samples at the negedge mid-cycle.
  - On read: at the posedge ending cycle c, capture mem_memdata into an internal read buffer at [8c+7:8c].
  - On the posedge when c=WORD_BYTES-1: copy the buffer to resp_rdata and go to RESP. Otherwise c increments.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; mem_en=0.
  - Next state is IDLE.
- Read data:
  - resp_rdata changes only at the end of a read.
  - It holds its value through subsequent cycles and through write requests. Writes never modify resp_rdata.
- Timing:
  - Request accepted at posedge P.
  - Memory strobes occur in the WORD_BYTES cycles after P.
  - resp_valid is high in cycle P+WORD_BYTES+1; earliest next acceptance is at posedge P+WORD_BYTES+2.
  - Throughput: one request per WORD_BYTES+2 cycles.
- req_valid while req_ready=0 is ignored; the requester holds the request until accepted.
- Address wrap: 0xFF+1 = 0x00 with no error.
- No alignment requirement.
- Reset mid-XFER:
  - Abort at once; mem_en drops asynchronously.
  - Bytes already written remain written; no resp_valid is generated for the aborted request.

Test Plan:
1. Memory preloaded 0x10..0x13 = 11,22,33,44; read at 0x10 -> mem_adr 10,11,12,13 on consecutive cycles with mem_memwrite=0; resp_rdata=0x44332211; resp_valid high exactly 1 cycle, 5 cycles after acceptance.
2. Write 0xDEADBEEF at 0x20 -> mem_writedata EF,BE,AD,DE at adr 20..23 with mem_memwrite=1; resp_valid pulse; resp_rdata unchanged. Then read 0x20 -> 0xDEADBEEF.
3. Read at 0xFE with 0xFE,0xFF,0x00,0x01 = A1,B2,C3,D4 -> mem_adr FE,FF,00,01; resp_rdata=0xD4C3B2A1.
4. req_valid held high with two queued reads -> req_ready=0 during XFER/RESP; second request accepted exactly 6 cycles after the first; both responses correct and in order.
5. Write 0x55667788 at 0x40 (memory pre-zeroed); assert reset_n=0 during the third XFER cycle -> all outputs zero immediately, no resp_valid. Memory 0x40=88 and 0x41=77; 0x42 and 0x43 stay 00. After release, a read at 0x40 returns 0x00007788.
6. Idle with req_valid=0 for 10 cycles -> mem_en stays 0, req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/mem_word_master.sv
// Word-to-byte memory initiator: turns one 32-bit read/write request into
// WORD_BYTES little-endian byte accesses on a negedge-sampled byte memory.
module mem_word_master #(
  parameter int ADDR_BITS  = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [8*WORD_BYTES-1:0] resp_rdata,
  output logic                    mem_en,
  output logic                    mem_memwrite,
  output logic [ADDR_BITS-1:0]    mem_adr,
  output logic [7:0]              mem_writedata,
  input  logic [7:0]              mem_memdata,
  output logic [1:0]              dbg_state
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_BITS-1:0]  base_q, base_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         rbuf_q, rbuf_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  xfer;

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE and the requester holds the request until then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          base_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        // Memory drove memdata at the mid-cycle negedge; capture it here.
        if (!write_q) begin
          rbuf_d[8*cnt_q +: 8] = mem_memdata;
        end
        if (cnt_q == LAST) begin
          state_d = RESP;
          if (!write_q) begin
            rdata_d = rbuf_d;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory-side outputs are decoded from registers only and forced to zero outside XFER.
  assign xfer          = (state_q == XFER);
  assign mem_en        = xfer;
  assign mem_memwrite  = xfer & write_q;
  assign mem_adr       = xfer ? (base_q + ADDR_BITS'(cnt_q)) : '0;
  assign mem_writedata = xfer ? wdata_q[8*cnt_q +: 8] : 8'h00;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_word_master.sv
// Directed bench for mem_word_master with a negedge byte-memory model.
module tb_mem_word_master;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic        mem_memwrite;
  logic [7:0]  mem_adr;
  logic [7:0]  mem_writedata;
  logic [7:0]  mem_memdata;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:255];
  logic [31:0] exp_q [$];
  int          checks;
  int          failures;

  mem_word_master #(.ADDR_BITS(8), .WORD_BYTES(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .mem_en        (mem_en),
    .mem_memwrite  (mem_memwrite),
    .mem_adr       (mem_adr),
    .mem_writedata (mem_writedata),
    .mem_memdata   (mem_memdata),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte memory: preload once, then act on every negedge
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
    mem_memdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (mem_memwrite) mem[mem_adr] = mem_writedata;
        else              mem_memdata = mem[mem_adr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one request from IDLE (called at posedge+1) and checks every cycle
  // of the transfer up to the return to IDLE.
  task automatic do_req(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    logic [7:0] a;
    check_eq({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a = addr + 8'(i);
      check_eq({tag, "_en"}, {31'd0, mem_en}, 32'd1);
      check_eq({tag, "_adr"}, {24'd0, mem_adr}, {24'd0, a});
      check_eq({tag, "_memwrite"}, {31'd0, mem_memwrite}, {31'd0, wr});
      if (wr) check_eq({tag, "_wdata"}, {24'd0, mem_writedata}, {24'd0, wd[8*i +: 8]});
      check_eq({tag, "_busy"}, {30'd0, req_ready, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check_eq({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check_eq({tag, "_resp_en"}, {30'd0, mem_en, req_ready}, 32'd0);
    check_eq({tag, "_rdata"}, resp_rdata, exp_rd);
    @(posedge clk); #1;
    check_eq({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int busy;
    int k;
    logic rdy;
    logic [31:0] e;
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 32'h0;
    #2;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_resp", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_mem", {14'd0, mem_en, mem_memwrite, mem_adr, mem_writedata}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: plain read
    do_req("t1_rd10", 1'b0, 8'h10, 32'h0, 32'h44332211);
    // 2: write leaves resp_rdata alone, then read it back
    do_req("t2_wr20", 1'b1, 8'h20, 32'hDEADBEEF, 32'h44332211);
    do_req("t2_rd20", 1'b0, 8'h20, 32'h0, 32'hDEADBEEF);
    // 3: address wrap
    do_req("t3_rdFE", 1'b0, 8'hFE, 32'h0, 32'hD4C3B2A1);

    // 4: back-to-back reads with req_valid held high
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'hDEADBEEF);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h10;
    @(posedge clk); #1;
    req_addr = 8'h20;
    n = 0; busy = 0; rdy = 1'b0;
    while (n < 20 && !rdy) begin
      rdy = req_ready;
      if (!req_ready) busy++;
      if (resp_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("t4_rdata1", resp_rdata, e);
      end
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    check_eq("t4_accept_gap", n, 32'd6);
    check_eq("t4_busy_cycles", busy, 32'd5);
    k = 0;
    while (!resp_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("t4_resp2_seen", {31'd0, resp_valid}, 32'd1);
    if (resp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("t4_rdata2", resp_rdata, e);
    end
    check_eq("t4_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // 5: reset during the third byte of a write
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h40;
    req_wdata = 32'h55667788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_mem", {14'd0, mem_en, mem_memwrite, mem_adr, mem_writedata}, 32'd0);
    check_eq("t5_rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("t5_rst_resp", {31'd0, resp_valid}, 32'd0);
    check_eq("t5_rst_rdata", resp_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("t5_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    check_eq("t5_mem40", {24'd0, mem[8'h40]}, 32'h88);
    check_eq("t5_mem41", {24'd0, mem[8'h41]}, 32'h77);
    check_eq("t5_mem42", {24'd0, mem[8'h42]}, 32'h00);
    check_eq("t5_mem43", {24'd0, mem[8'h43]}, 32'h00);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_req("t5_rd40", 1'b0, 8'h40, 32'h0, 32'h00007788);

    // 6: idle stays quiet
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("t6_idle", {29'd0, mem_en, req_ready, resp_valid}, 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
